// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry,
// common to the transmit and receive paths.
package uart_pkg;

   localparam int OVERSAMPLE_DEF = 16;
   localparam int DATA_BITS_DEF  = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser that brings an asynchronous single-bit input into the
// i_clk domain. RESET_VAL is the idle level of the line being synchronised.
module bit_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES:0] chain;

   assign chain[0] = i_d;
   assign o_q      = chain[STAGES];

   // NOTE: reset to the idle level so leaving reset never looks like a falling edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) chain[STAGES:1] <= {STAGES{RESET_VAL}};
      else       chain[STAGES:1] <= chain[STAGES-1:0];
   end

endmodule

// File: rtl/receiver.sv
// UART 8N1 receive path: oversampled start detect, mid-bit sampling, stop-bit check.
// Good frames pulse o_valid with o_data; a low stop bit pulses o_frame_err.
module receiver
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
   parameter int DATA_BITS   = DATA_BITS_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_baud,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_frame_err,
   output logic                 o_busy
);

   localparam int TC_W = $clog2(OVERSAMPLE);
   localparam int BI_W = $clog2(DATA_BITS + 1);

   localparam logic [TC_W-1:0] TC_MID  = TC_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TC_W-1:0] TC_LAST = TC_W'(OVERSAMPLE - 1);
   localparam logic [TC_W-1:0] TC_ONE  = TC_W'(1);
   localparam logic [BI_W-1:0] BI_LAST = BI_W'(DATA_BITS - 1);
   localparam logic [BI_W-1:0] BI_ONE  = BI_W'(1);

   logic rx_s;

   rx_state_t            state, state_n;
   logic [TC_W-1:0]      tc, tc_n;
   logic [BI_W-1:0]      bi, bi_n;
   logic [DATA_BITS-1:0] sh, sh_n;
   logic [DATA_BITS-1:0] data_q, data_n;
   logic                 valid_q, valid_n;
   logic                 err_q, err_n;

   bit_sync #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (1'b1)
   ) u_rx_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_rx),
      .o_q   (rx_s)
   );

   // NOTE: every *_n gets its default first, so no path can infer a latch.
   always_comb begin
      state_n = state;
      tc_n    = tc;
      bi_n    = bi;
      sh_n    = sh;
      data_n  = data_q;
      valid_n = 1'b0;
      err_n   = 1'b0;

      if (i_baud) begin
         unique case (state)
            IDLE: begin
               if (!rx_s) begin
                  state_n = START;
                  tc_n    = '0;
                  bi_n    = '0;
               end
            end
            START: begin
               if (tc == TC_MID) begin
                  tc_n    = '0;
                  bi_n    = '0;
                  state_n = rx_s ? IDLE : DATA;
               end else begin
                  tc_n = tc + TC_ONE;
               end
            end
            DATA: begin
               if (tc == TC_LAST) begin
                  // LSB arrives first, so shifting in from the top leaves it at bit 0.
                  sh_n = {rx_s, sh[DATA_BITS-1:1]};
                  tc_n = '0;
                  bi_n = bi + BI_ONE;
                  if (bi == BI_LAST) state_n = STOP;
               end else begin
                  tc_n = tc + TC_ONE;
               end
            end
            STOP: begin
               if (tc == TC_LAST) begin
                  tc_n = '0;
                  if (rx_s) begin
                     data_n  = sh;
                     valid_n = 1'b1;
                     state_n = IDLE;
                  end else begin
                     err_n   = 1'b1;
                     state_n = BREAK;
                  end
               end else begin
                  tc_n = tc + TC_ONE;
               end
            end
            BREAK: begin
               if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= IDLE;
         tc      <= '0;
         bi      <= '0;
         sh      <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_n;
         tc      <= tc_n;
         bi      <= bi_n;
         sh      <= sh_n;
         data_q  <= data_n;
         valid_q <= valid_n;
         err_q   <= err_n;
      end
   end

   assign o_data      = data_q;
   assign o_valid     = valid_q;
   assign o_frame_err = err_q;
   assign o_busy      = (state != IDLE);

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for the UART receiver: table-driven frames, hand-written
// corner sequences and randomized frames checked against a frame-level model.
module tb_receiver;

   localparam int OS        = 16;
   localparam int BAUD_DIV  = 4;
   localparam int BIT_CLKS  = OS * BAUD_DIV;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic       i_baud;
   logic       i_rx;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_frame_err;
   logic       o_busy;

   int tests = 0;
   int fails = 0;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
   } event_t;

   event_t ev_q[$];

   typedef struct {
      logic [7:0] data;
      bit         stop_ok;
      int         gap;
      bit         exp_err;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[8];

   receiver #(
      .OVERSAMPLE  (OS),
      .DATA_BITS   (8),
      .SYNC_STAGES (2)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_baud      (i_baud),
      .i_rx        (i_rx),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .o_frame_err (o_frame_err),
      .o_busy      (o_busy)
   );

   always #5 i_clk = ~i_clk;

   int baud_cnt = 0;
   always @(negedge i_clk) begin
      baud_cnt = (baud_cnt == BAUD_DIV - 1) ? 0 : baud_cnt + 1;
      i_baud   = (baud_cnt == 0);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Event monitor: records every output pulse for the frame-level comparisons.
   logic prev_valid = 1'b0;
   always @(negedge i_clk) begin
      if (o_valid || o_frame_err) begin
         check("pulse_exclusive", {31'b0, o_valid & o_frame_err}, 32'd0);
         ev_q.push_back('{is_err: o_frame_err, data: o_data});
      end
      if (o_valid) check("valid_one_cycle", {31'b0, prev_valid}, 32'd0);
      prev_valid = o_valid;
   end

   task automatic send_bit(input logic b, input int nbits);
      i_rx = b;
      repeat (nbits * BIT_CLKS) @(negedge i_clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int gap);
      send_bit(1'b0, 1);
      for (int i = 0; i < 8; i++) send_bit(d[i], 1);
      send_bit(stop_ok, 1);
      if (gap > 0) send_bit(1'b1, gap);
   endtask

   task automatic check_events(input string name, input int exp_n, input bit exp_err,
                               input logic [7:0] exp_data);
      event_t ev;
      check({name, "_count"}, ev_q.size(), exp_n);
      if (ev_q.size() > 0 && exp_n > 0) begin
         ev = ev_q.pop_front();
         check({name, "_kind"}, {31'b0, ev.is_err}, {31'b0, exp_err});
         if (!exp_err) check({name, "_data"}, {24'b0, ev.data}, {24'b0, exp_data});
      end
      ev_q.delete();
   endtask

   initial begin
      logic [7:0] last_good;
      bit         saw_busy;

      vecs[0] = '{8'hA5, 1'b1, 1, 1'b0, 8'hA5};
      vecs[1] = '{8'h00, 1'b1, 0, 1'b0, 8'h00};
      vecs[2] = '{8'hFF, 1'b1, 1, 1'b0, 8'hFF};
      vecs[3] = '{8'h3C, 1'b0, 2, 1'b1, 8'hFF};
      vecs[4] = '{8'h5A, 1'b1, 1, 1'b0, 8'h5A};
      vecs[5] = '{8'h81, 1'b1, 0, 1'b0, 8'h81};
      vecs[6] = '{8'hC3, 1'b0, 1, 1'b1, 8'h81};
      vecs[7] = '{8'h01, 1'b1, 1, 1'b0, 8'h01};

      // Reset state
      i_rst  = 1'b1;
      i_rx   = 1'b1;
      i_baud = 1'b0;
      repeat (4) @(negedge i_clk);
      check("rst_data",  {24'b0, o_data}, 32'd0);
      check("rst_valid", {31'b0, o_valid}, 32'd0);
      check("rst_err",   {31'b0, o_frame_err}, 32'd0);
      check("rst_busy",  {31'b0, o_busy}, 32'd0);
      i_rst = 1'b0;
      send_bit(1'b1, 2);
      check_events("idle", 0, 1'b0, 8'h00);

      // Table-driven frames
      for (int v = 0; v < 8; v++) begin
         send_frame(vecs[v].data, vecs[v].stop_ok, 0);
         check_events($sformatf("vec%0d", v), 1, vecs[v].exp_err, vecs[v].data);
         check($sformatf("vec%0d_odata", v), {24'b0, o_data}, {24'b0, vecs[v].exp_data});
         if (vecs[v].gap > 0) send_bit(1'b1, vecs[v].gap);
      end

      // 3-tick glitch: start detected, rejected at the mid-bit check
      saw_busy = 1'b0;
      i_rx = 1'b0;
      repeat (3 * BAUD_DIV) begin
         @(negedge i_clk);
         saw_busy |= o_busy;
      end
      i_rx = 1'b1;
      repeat (12 * BAUD_DIV) begin
         @(negedge i_clk);
         saw_busy |= o_busy;
      end
      check("glitch_busy_seen", {31'b0, saw_busy}, 32'd1);
      check("glitch_busy_low",  {31'b0, o_busy}, 32'd0);
      send_bit(1'b1, 1);
      check_events("glitch", 0, 1'b0, 8'h00);

      // Break: 30 bit times low gives exactly one frame error
      send_bit(1'b0, 30);
      send_bit(1'b1, 2);
      check_events("break", 1, 1'b1, 8'h00);
      check("break_odata", {24'b0, o_data}, 32'h01);
      send_frame(8'h55, 1'b1, 1);
      check_events("after_break", 1, 1'b0, 8'h55);

      // Reset during DATA bit 4 of 0x81 drops the partial byte
      send_bit(1'b0, 1);
      for (int i = 0; i < 4; i++) send_bit(1'(8'h81 >> i), 1);
      i_rx = 1'b0;
      repeat (BIT_CLKS / 2) @(negedge i_clk);
      check("pre_rst_busy", {31'b0, o_busy}, 32'd1);
      i_rst = 1'b1;
      i_rx  = 1'b1;
      @(negedge i_clk);
      check("midrst_data",  {24'b0, o_data}, 32'd0);
      check("midrst_valid", {31'b0, o_valid}, 32'd0);
      check("midrst_err",   {31'b0, o_frame_err}, 32'd0);
      check("midrst_busy",  {31'b0, o_busy}, 32'd0);
      i_rst = 1'b0;
      send_bit(1'b1, 2);
      check_events("midrst_drop", 0, 1'b0, 8'h00);
      send_frame(8'h81, 1'b1, 1);
      check_events("after_rst", 1, 1'b0, 8'h81);

      // Randomized frames against a frame-level model
      last_good = 8'h81;
      for (int n = 0; n < 24; n++) begin
         logic [7:0] d;
         bit         ok;
         int         gap;
         d   = 8'($urandom_range(0, 255));
         ok  = ($urandom_range(0, 4) != 0);
         gap = ok ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3));
         send_frame(d, ok, 0);
         if (ok) last_good = d;
         check_events($sformatf("rand%0d", n), 1, !ok, d);
         check($sformatf("rand%0d_odata", n), {24'b0, o_data}, {24'b0, last_good});
         if (gap > 0) send_bit(1'b1, gap);
      end

      send_bit(1'b1, 1);
      check("final_busy", {31'b0, o_busy}, 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
